// File: rtl/alu_pkg.sv
// Shared types for the accumulator datapath: ALU op codes and sequence tracker states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOT  = 3'b101,
        OP_PASS = 3'b110,
        OP_CLR  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OP   = 2'b01,
        S_A    = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: res = c op a, with carry/borrow and signed overflow for ADD/SUB.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Result and flag selection; the extra MSB of sum/diff gives carry-out and borrow.
    always_comb begin
        sum   = {1'b0, c} + {1'b0, a};
        diff  = {1'b0, c} - {1'b0, a};
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (c[WIDTH-1] == a[WIDTH-1]) && (sum[WIDTH-1] != c[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (c[WIDTH-1] != a[WIDTH-1]) && (diff[WIDTH-1] != c[WIDTH-1]);
            end
            OP_AND:  res = c & a;
            OP_OR:   res = c | a;
            OP_XOR:  res = c ^ a;
            OP_NOT:  res = ~a;
            OP_PASS: res = a;
            OP_CLR:  res = '0;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// Accumulator datapath loaded by a 3-phase controller (enALU -> enA -> enC),
// with an enable-order tracker that pulses done and raises a sticky seq_err.
//
//   state  | meaning
//   S_IDLE | no sequence in progress (after reset, a completed store, or an error)
//   S_OP   | op code latched, waiting for enA
//   S_A    | operand latched, waiting for enC
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLKb,
    input  logic             RST,
    input  logic             enALU,
    input  logic             enA,
    input  logic             enC,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             done,
    output logic             seq_err
);

    alu_op_t          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             done_d;
    logic             err_d;
    logic             multi_en;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .op    (op_q),
        .c     (result),
        .a     (a_q),
        .res   (alu_res),
        .carry (alu_carry),
        .ovf   (alu_ovf)
    );

    assign multi_en = (enALU & enA) | (enALU & enC) | (enA & enC);

    // Next tracker state: in-order steps advance, anything else drops to idle with an error.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (multi_en) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (enALU) begin
            state_d = S_OP;
        end else if (enA) begin
            if (state_q == S_OP) begin
                state_d = S_A;
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end else if (enC) begin
            state_d = S_IDLE;
            if (state_q == S_A) begin
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Registers, flags and tracker; loads happen even on out-of-order enables.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            op_q    <= OP_ADD;
            a_q     <= '0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            seq_err <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            if (enALU) begin
                op_q <= alu_op_t'(op_in);
            end
            if (enA) begin
                a_q <= data_in;
            end
            if (enC) begin
                result <= alu_res;
                carry  <= alu_carry;
                ovf    <= alu_ovf;
                zero   <= (alu_res == '0);
            end
            done    <= done_d;
            seq_err <= seq_err | err_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: stimulus pushes expected post-store state,
// a monitor pops and compares after every enC or RST edge.
module tb_alu_datapath;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0] result;
        logic       carry;
        logic       zero;
        logic       ovf;
        logic       done;
        logic       seq_err;
    } exp_t;

    logic       CLKb;
    logic       RST;
    logic       enALU;
    logic       enA;
    logic       enC;
    logic [2:0] op_in;
    logic [3:0] data_in;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       ovf;
    logic       done;
    logic       seq_err;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic store_seen = 1'b0;

    alu_datapath #(.WIDTH(4)) dut (
        .CLKb    (CLKb),
        .RST     (RST),
        .enALU   (enALU),
        .enA     (enA),
        .enC     (enC),
        .op_in   (op_in),
        .data_in (data_in),
        .result  (result),
        .carry   (carry),
        .zero    (zero),
        .ovf     (ovf),
        .done    (done),
        .seq_err (seq_err)
    );

    initial begin
        CLKb = 1'b0;
        forever #5 CLKb = ~CLKb;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Remember whether the last rising edge stored (enC) or reset, so the monitor knows to pop.
    always @(posedge CLKb) store_seen <= enC | RST;

    // Monitor: compare the registered outputs against the oldest expectation.
    always @(negedge CLKb) begin
        if (store_seen === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result",  {4'd0, result},  {4'd0, e.result});
                chk("carry",   {7'd0, carry},   {7'd0, e.carry});
                chk("zero",    {7'd0, zero},    {7'd0, e.zero});
                chk("ovf",     {7'd0, ovf},     {7'd0, e.ovf});
                chk("done",    {7'd0, done},    {7'd0, e.done});
                chk("seq_err", {7'd0, seq_err}, {7'd0, e.seq_err});
            end
        end
    end

    task automatic tick(input logic rst, input logic e_alu, input logic e_a, input logic e_c,
                        input alu_op_t op, input logic [3:0] d);
        @(negedge CLKb);
        RST     = rst;
        enALU   = e_alu;
        enA     = e_a;
        enC     = e_c;
        op_in   = op;
        data_in = d;
    endtask

    task automatic push(input logic [3:0] r, input logic c, input logic z, input logic o,
                        input logic dn, input logic se);
        exp_t e;
        e = '{result: r, carry: c, zero: z, ovf: o, done: dn, seq_err: se};
        exp_q.push_back(e);
    endtask

    // One in-order enALU -> enA -> enC sequence, then confirm done lasted one cycle.
    task automatic run_seq(input alu_op_t op, input logic [3:0] a, input logic [3:0] r,
                           input logic c, input logic z, input logic o);
        tick(1'b0, 1'b1, 1'b0, 1'b0, op, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, OP_ADD, a);
        push(r, c, z, o, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, OP_ADD, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);
        @(negedge CLKb);
        chk("done_one_cycle", {7'd0, done}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two edges with every enable asserted.
        RST = 1'b1; enALU = 1'b1; enA = 1'b1; enC = 1'b1; op_in = OP_PASS; data_in = 4'hF;
        push(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, OP_PASS, 4'hF);
        tick(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);

        // ADD with carry-out.
        run_seq(OP_PASS, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
        run_seq(OP_ADD,  4'hB, 4'h2, 1'b1, 1'b0, 1'b0);

        // SUB with borrow, then exact zero.
        run_seq(OP_PASS, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
        run_seq(OP_SUB,  4'h5, 4'hE, 1'b1, 1'b0, 1'b0);
        run_seq(OP_PASS, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0);
        run_seq(OP_SUB,  4'h5, 4'h0, 1'b0, 1'b1, 1'b0);

        // Signed overflow, then XOR back to zero.
        run_seq(OP_PASS, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
        run_seq(OP_ADD,  4'h1, 4'h8, 1'b0, 1'b0, 1'b1);
        run_seq(OP_XOR,  4'h8, 4'h0, 1'b0, 1'b1, 1'b0);

        // Logic ops.
        run_seq(OP_PASS, 4'hC, 4'hC, 1'b0, 1'b0, 1'b0);
        run_seq(OP_AND,  4'h6, 4'h4, 1'b0, 1'b0, 1'b0);
        run_seq(OP_OR,   4'h3, 4'h7, 1'b0, 1'b0, 1'b0);
        run_seq(OP_NOT,  4'h5, 4'hA, 1'b0, 1'b0, 1'b0);
        run_seq(OP_CLR,  4'hF, 4'h0, 1'b0, 1'b1, 1'b0);

        // Out of order: enC alone straight after reset.
        push(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);
        push(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, OP_ADD, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);
        @(negedge CLKb);
        chk("seq_err_sticky", {7'd0, seq_err}, 8'd1);
        chk("no_done_on_err", {7'd0, done}, 8'd0);

        // Reset after the enA edge, then a lone enC is out of order.
        push(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, OP_PASS, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, OP_ADD, 4'h9);
        push(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);
        push(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, OP_ADD, 4'h0);

        // enA and enC on one edge: store uses old a_q (0), new a_q (3) shows on the next store.
        push(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1, OP_ADD, 4'h3);
        push(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, OP_ADD, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 4'h0);
        repeat (3) @(negedge CLKb);

        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
